// File: rtl/id_stage_pipe_pkg.sv
// Shared opcode/funct constants, FSM encoding and small decode helpers for the
// MIPS decode stage.
package id_stage_pipe_pkg;

    localparam int REGFILE_SIZE = 32;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;
    localparam logic [5:0] FN_JR      = 6'h08;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    // Logical immediates are zero-extended; everything else sign-extends.
    function automatic logic imm_is_zext(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    endfunction

    function automatic logic op_uses_rt(input logic [5:0] op);
        return (op == OP_SPECIAL) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    endfunction

    // Opcodes above BGTZ are I-type ALU ops or loads, which all write rt (except SW).
    function automatic logic op_writes(input logic [5:0] op, input logic [5:0] funct);
        return ((op == OP_SPECIAL) && (funct != FN_JR)) || (op == OP_JAL) ||
               ((op > OP_BGTZ) && (op != OP_SW));
    endfunction

endpackage

// File: rtl/regfile_bypass.sv
// 2-read / 1-write register file with synchronous clear, hardwired r0 and
// write-through bypass so a same-cycle write is visible on the read ports.
module regfile_bypass #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     we,
    input  logic [$clog2(NREG)-1:0]  wadr,
    input  logic [XLEN-1:0]          wdata,
    input  logic [$clog2(NREG)-1:0]  radr1,
    input  logic [$clog2(NREG)-1:0]  radr2,
    output logic [XLEN-1:0]          rdata1,
    output logic [XLEN-1:0]          rdata2
);

    logic [XLEN-1:0] mem [NREG];

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (wadr != '0)) begin
            mem[wadr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = mem[radr1];
        if (radr1 == '0) begin
            rdata1 = '0;
        end else if (we && (wadr == radr1)) begin
            rdata1 = wdata;
        end
    end

    always_comb begin
        rdata2 = mem[radr2];
        if (radr2 == '0) begin
            rdata2 = '0;
        end else if (we && (wadr == radr2)) begin
            rdata2 = wdata;
        end
    end

endmodule

// File: rtl/id_stage_pipe.sv
// MIPS decode stage: operand read, dest/immediate decode, load-use interlock
// and the registered ID/EX boundary feeding execute.
module id_stage_pipe
    import id_stage_pipe_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NREG       = REGFILE_SIZE,
    parameter int LOAD_STALL = 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     if_valid,
    output logic                     if_ready,
    input  logic [31:0]              if_ins,
    input  logic                     flush,
    input  logic                     wb_en,
    input  logic [$clog2(NREG)-1:0]  wb_adr,
    input  logic [XLEN-1:0]          wb_data,
    output logic                     ex_valid,
    input  logic                     ex_ready,
    output logic [XLEN-1:0]          ex_rdata1,
    output logic [XLEN-1:0]          ex_rdata2,
    output logic [XLEN-1:0]          ex_imm,
    output logic [$clog2(NREG)-1:0]  ex_wadr,
    output logic                     ex_we,
    output logic                     ex_is_load,
    output logic [5:0]               ex_opcode,
    output logic [5:0]               ex_funct,
    output state_t                   dbg_state
);

    localparam int AW = $clog2(NREG);
    localparam int CW = (LOAD_STALL > 1) ? $clog2(LOAD_STALL) : 1;

    logic [5:0]      op;
    logic [5:0]      funct;
    logic [AW-1:0]   rs_a;
    logic [AW-1:0]   rt_a;
    logic [AW-1:0]   rd_a;
    logic [AW-1:0]   dec_wadr;
    logic            dec_we;
    logic            dec_uses_rt;
    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            hazard;
    logic            accept;
    state_t          state;
    logic [CW-1:0]   cnt;

    assign op    = if_ins[31:26];
    assign funct = if_ins[5:0];
    assign rs_a  = AW'(if_ins[25:21]);
    assign rt_a  = AW'(if_ins[20:16]);
    assign rd_a  = AW'(if_ins[15:11]);

    always_comb begin
        dec_wadr = rt_a;
        if (op == OP_SPECIAL) begin
            dec_wadr = rd_a;
        end else if (op == OP_JAL) begin
            dec_wadr = AW'(31);
        end
        dec_we      = op_writes(op, funct) && (dec_wadr != '0);
        dec_uses_rt = op_uses_rt(op);
        if (imm_is_zext(op)) begin
            dec_imm = {{(XLEN-16){1'b0}}, if_ins[15:0]};
        end else begin
            dec_imm = {{(XLEN-16){if_ins[15]}}, if_ins[15:0]};
        end
    end

    regfile_bypass #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .CLK    (CLK),
        .RST    (RST),
        .we     (wb_en),
        .wadr   (wb_adr),
        .wdata  (wb_data),
        .radr1  (rs_a),
        .radr2  (rt_a),
        .rdata1 (rd1),
        .rdata2 (rd2)
    );

    // A load still sitting in ID/EX cannot forward its data, so a consumer
    // of its destination must wait.
    assign hazard = ex_valid && ex_is_load && (ex_wadr != '0) &&
                    ((ex_wadr == rs_a) || (dec_uses_rt && (ex_wadr == rt_a)));

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; valid never depends on ready, and ex_* hold while
    // ex_valid && !ex_ready.
    assign if_ready = (state == ST_RUN) && !flush && (!ex_valid || ex_ready) && !hazard;
    assign accept   = if_valid && if_ready;
    assign dbg_state = state;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_RUN;
            cnt        <= '0;
            ex_valid   <= 1'b0;
            ex_rdata1  <= '0;
            ex_rdata2  <= '0;
            ex_imm     <= '0;
            ex_wadr    <= '0;
            ex_we      <= 1'b0;
            ex_is_load <= 1'b0;
            ex_opcode  <= '0;
            ex_funct   <= '0;
        end else if (flush) begin
            state    <= ST_RUN;
            cnt      <= '0;
            ex_valid <= 1'b0;
        end else if (state == ST_STALL) begin
            ex_valid <= 1'b0;
            cnt      <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                state <= ST_RUN;
            end
        end else if (hazard && if_valid && ex_ready) begin
            ex_valid <= 1'b0;
            if (LOAD_STALL > 1) begin
                state <= ST_STALL;
                cnt   <= CW'(LOAD_STALL - 1);
            end
        end else if (accept) begin
            ex_valid   <= 1'b1;
            ex_rdata1  <= rd1;
            ex_rdata2  <= rd2;
            ex_imm     <= dec_imm;
            ex_wadr    <= dec_wadr;
            ex_we      <= dec_we;
            ex_is_load <= (op == OP_LW);
            ex_opcode  <= op;
            ex_funct   <= funct;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

endmodule
